// File: rtl/dec8out_seq.sv
// Registered 3-to-8 one-hot decoder with handshake and programmable hold/gap timing.
// Define DEC8OUT_INVERT_EN for active-low (one-cold) o_one_hot.
module dec8out_seq #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_bin,
  input  logic       i_en,
  output logic       o_ready,
  output logic [7:0] o_one_hot,
  output logic       o_active,
  output logic       o_done
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StGap  = 2'd2
  } state_e;

`ifdef DEC8OUT_INVERT_EN
  localparam logic [7:0] PolMask = 8'hFF;
`else
  localparam logic [7:0] PolMask = 8'h00;
`endif

  // Counters hold "cycles remaining minus one" so 256 still fits in 8 bits.
  localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GapLoad  = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] one_hot_q, one_hot_d;
  logic       active_q, active_d;
  logic       done_q, done_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    one_hot_d = one_hot_q;
    active_d  = active_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_en) begin
          state_d   = StHold;
          cnt_d     = HoldLoad;
          one_hot_d = (8'b1 << i_bin) ^ PolMask;
          active_d  = 1'b1;
          done_d    = (HoldLoad == 8'd0);
        end
      end
      StHold: begin
        if (cnt_q == 8'd0) begin
          one_hot_d = PolMask;
          active_d  = 1'b0;
          if (GAP_CYCLES > 0) begin
            state_d = StGap;
            cnt_d   = GapLoad;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d  = cnt_q - 8'd1;
          // o_done is registered, so raise it on the edge that makes the count reach zero.
          done_d = (cnt_q == 8'd1);
        end
      end
      StGap: begin
        if (cnt_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      one_hot_q <= PolMask;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      one_hot_q <= one_hot_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  assign o_ready   = (state_q == StIdle);
  assign o_one_hot = one_hot_q;
  assign o_active  = active_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_dec8out_seq.sv
// Bench for dec8out_seq: two instances (HOLD=4/GAP=1 and HOLD=1/GAP=0) against a
// timestamp-based reference model; directed scenarios followed by random stimulus.
module tb_dec8out_seq;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [2:0] i_bin = 3'd0;
  logic       i_en  = 1'b0;

  logic       rdy0, act0, dn0, rdy1, act1, dn1;
  logic [7:0] oh0, oh1;

  int n_checks = 0;
  int n_bad    = 0;
  int edge_cnt = 0;

  // Model: an instance is busy for HOLD+GAP edges after the edge that accepted a code.
  bit         have [2];
  int         acc  [2];
  logic [2:0] code [2];

`ifdef DEC8OUT_INVERT_EN
  localparam logic [7:0] Pol = 8'hFF;
`else
  localparam logic [7:0] Pol = 8'h00;
`endif

  always #5 i_clk = ~i_clk;

  dec8out_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) u_dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_bin(i_bin), .i_en(i_en),
    .o_ready(rdy0), .o_one_hot(oh0), .o_active(act0), .o_done(dn0)
  );

  dec8out_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_bin(i_bin), .i_en(i_en),
    .o_ready(rdy1), .o_one_hot(oh1), .o_active(act1), .o_done(dn1)
  );

  function automatic int hold_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic bit model_ready(input int i);
    return !have[i] || ((edge_cnt - acc[i]) >= hold_of(i) + gap_of(i));
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, edge_cnt, got, exp);
    end
  endtask

  task automatic check_inst(input int i, input logic [7:0] oh, input logic act, input logic dn,
                            input logic rdy);
    int         k;
    bit         in_hold;
    logic [7:0] exp_oh;
    k       = edge_cnt - acc[i];
    in_hold = have[i] && (k < hold_of(i));
    exp_oh  = in_hold ? ((8'h01 << code[i]) ^ Pol) : Pol;
    check_eq($sformatf("one_hot%0d", i), oh, exp_oh);
    check_eq($sformatf("active%0d", i), {7'd0, act}, {7'd0, in_hold});
    check_eq($sformatf("done%0d", i), {7'd0, dn}, {7'd0, in_hold && (k == hold_of(i) - 1)});
    check_eq($sformatf("ready%0d", i), {7'd0, rdy}, {7'd0, model_ready(i)});
  endtask

  task automatic tick(input logic r, input logic e, input logic [2:0] b);
    i_rst = r;
    i_en  = e;
    i_bin = b;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        have[i] = 1'b0;
      end else if (e && model_ready(i)) begin
        have[i] = 1'b1;
        acc[i]  = edge_cnt + 1;
        code[i] = b;
      end
    end
    @(posedge i_clk);
    edge_cnt++;
    #1;
    check_inst(0, oh0, act0, dn0, rdy0);
    check_inst(1, oh1, act1, dn1, rdy1);
  endtask

  initial begin
    logic [2:0] nxt;
    for (int i = 0; i < 2; i++) begin
      have[i] = 1'b0;
      acc[i]  = 0;
      code[i] = 3'd0;
    end
    #2;
    // Reset, then idle with i_en low.
    tick(1'b1, 1'b0, 3'd0);
    tick(1'b1, 1'b0, 3'd0);
    for (int n = 0; n < 3; n++) tick(1'b0, 1'b0, 3'd6);
    // Single decode of 5, then drain.
    tick(1'b0, 1'b1, 3'd5);
    for (int n = 0; n < 8; n++) tick(1'b0, 1'b0, 3'($urandom_range(0, 7)));
    // i_en held high; advance the code only when instance 0 takes one.
    nxt = 3'd0;
    for (int n = 0; n < 52; n++) begin
      tick(1'b0, 1'b1, nxt);
      if (have[0] && acc[0] == edge_cnt) nxt = nxt + 3'd1;
    end
    for (int n = 0; n < 8; n++) tick(1'b0, 1'b0, 3'd0);
    // Reset during the second hold cycle drops the code and its o_done.
    tick(1'b0, 1'b1, 3'd3);
    tick(1'b0, 1'b0, 3'd3);
    tick(1'b1, 1'b1, 3'd3);
    tick(1'b0, 1'b0, 3'd0);
    tick(1'b0, 1'b0, 3'd0);
    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      tick(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
